puf_response_checker: RTL and testbench

Downstream consumer of the PUF authentication sequencer. It compacts the scan-out response captured during the authentication window into a MISR signature. On the sequencer's capture pulse it compares that signature and the shift count against the expected values. It reports pass/fail and keeps a consecutive-failure count that feeds the tamper/lockout logic.

---
 rtl/puf_response_checker_if.sv | 35 +++
 rtl/puf_response_checker.sv | 177 +++++++++++++++++
 tb/tb_puf_response_checker.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_response_checker_if.sv
// puf_response_checker_if: handshake and result bundle between the PUF
// authentication sequencer (master) and the response checker (slave).
interface puf_response_checker_if #(
  parameter int unsigned CHAINS = 8,
  parameter int unsigned SIG_W  = 32
);
  // Sequencer -> checker
  logic              auth_start;
  logic              is_auth;
  logic [CHAINS-1:0] scan_data;
  logic              auth_capture;
  logic [15:0]       l_scan;
  logic [SIG_W-1:0]  expected_sig;

  // Checker -> sequencer / tamper logic
  logic [SIG_W-1:0]  sig_out;
  logic [15:0]       shift_count;
  logic              result_valid;
  logic              auth_pass;
  logic              auth_fail;
  logic [7:0]        fail_count;
  logic              locked;

  modport master (
    output auth_start, is_auth, scan_data, auth_capture, l_scan, expected_sig,
    input  sig_out, shift_count, result_valid, auth_pass, auth_fail,
           fail_count, locked
  );

  modport slave (
    input  auth_start, is_auth, scan_data, auth_capture, l_scan, expected_sig,
    output sig_out, shift_count, result_valid, auth_pass, auth_fail,
           fail_count, locked
  );
endinterface

// File: rtl/puf_response_checker.sv
// puf_response_checker: compacts the authentication-window scan-out into a
// MISR signature, compares signature and shift count against golden values
// on the capture pulse, publishes a pass/fail verdict and tracks consecutive
// failures.
// Optional build macro PUF_LOCKOUT_EN: adds a LOCKED state entered when the
// consecutive-failure count reaches MAX_FAILS; only rst leaves it.
module puf_response_checker #(
  parameter int unsigned     CHAINS    = 8,
  parameter int unsigned     SIG_W     = 32,
  parameter logic [SIG_W-1:0] POLY     = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED     = 32'h00000000,
  parameter int unsigned     MAX_FAILS = 3
) (
  input logic                    clk,
  input logic                    rst,
  puf_response_checker_if.slave  bus
);

  // COMPARE latches the match, REPORT publishes it one edge later so the
  // verdict appears two edges after the capture edge.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COMPARE,
    S_REPORT
`ifdef PUF_LOCKOUT_EN
    , S_LOCKED
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             rv_q, rv_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [7:0]       fcnt_q, fcnt_d;

  logic [SIG_W-1:0] scan_ext;
  logic [SIG_W-1:0] misr_next;

`ifdef PUF_LOCKOUT_EN
  localparam logic [7:0] LOCK_AT = MAX_FAILS[7:0];
  logic locked_q, locked_d;
`endif

  // MISR next value: shift, polynomial feedback, XOR in zero-extended scan data
  always_comb begin
    scan_ext               = '0;
    scan_ext[CHAINS-1:0]   = bus.scan_data;
    misr_next = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ scan_ext;
  end

  // Next-state and datapath updates for the verdict FSM
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    rv_d     = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    fcnt_d   = fcnt_q;
`ifdef PUF_LOCKOUT_EN
    locked_d = locked_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.auth_start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        // A restart wins over both compaction and capture in the same cycle.
        if (bus.auth_start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_ARMED;
        end else begin
          if (bus.is_auth) begin
            sig_d = misr_next;
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          end
          if (bus.auth_capture) begin
            state_d = S_COMPARE;
          end
        end
      end

      S_COMPARE: begin
        match_d = (sig_q == bus.expected_sig) && (cnt_q == bus.l_scan);
        state_d = S_REPORT;
      end

      S_REPORT: begin
        rv_d    = 1'b1;
        pass_d  = match_q;
        fail_d  = !match_q;
        state_d = S_IDLE;
        if (match_q) begin
          fcnt_d = '0;
        end else if (fcnt_q != 8'hFF) begin
          fcnt_d = fcnt_q + 8'd1;
        end
`ifdef PUF_LOCKOUT_EN
        if (!match_q && (fcnt_d >= LOCK_AT)) begin
          locked_d = 1'b1;
          state_d  = S_LOCKED;
        end
`endif
      end

`ifdef PUF_LOCKOUT_EN
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      rv_q     <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      fcnt_q   <= '0;
`ifdef PUF_LOCKOUT_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      rv_q     <= rv_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      fcnt_q   <= fcnt_d;
`ifdef PUF_LOCKOUT_EN
      locked_q <= locked_d;
`endif
    end
  end

  assign bus.sig_out      = sig_q;
  assign bus.shift_count  = cnt_q;
  assign bus.result_valid = rv_q;
  assign bus.auth_pass    = pass_q;
  assign bus.auth_fail    = fail_q;
  assign bus.fail_count   = fcnt_q;
`ifdef PUF_LOCKOUT_EN
  assign bus.locked       = locked_q;
`else
  assign bus.locked       = 1'b0;
`endif

endmodule

// File: tb/tb_puf_response_checker.sv
// tb_puf_response_checker: scoreboard bench for puf_response_checker.
// Lockout checks are compiled in when PUF_LOCKOUT_EN is defined; otherwise
// fail_count saturation is exercised.
module tb_puf_response_checker;

  localparam int unsigned CHAINS    = 8;
  localparam int unsigned SIG_W     = 32;
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [31:0] SEED      = 32'h00000000;
  localparam int unsigned MAX_FAILS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_response_checker_if #(.CHAINS(CHAINS), .SIG_W(SIG_W)) bus ();

  puf_response_checker #(
    .CHAINS(CHAINS), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED),
    .MAX_FAILS(MAX_FAILS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       pass;
    logic       fail;
    logic [7:0] fcnt;
    logic       lk;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // reference model state
  logic [31:0] m_sig;
  logic [15:0] m_cnt;
  logic [7:0]  m_fcnt;
  bit          m_armed;
  bit          m_locked;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [7:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {24'h0, d};
  endfunction

  // verdict monitor: pops the scoreboard whenever a result is published
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.result_valid) begin
      if (sb.size() == 0) begin
        chk_eq("spurious_valid", bus.result_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk_eq("valid_cycle", cyc, e.cyc);
        chk_eq("auth_pass", bus.auth_pass, e.pass);
        chk_eq("auth_fail", bus.auth_fail, e.fail);
        chk_eq("fail_count", bus.fail_count, e.fcnt);
        chk_eq("locked", bus.locked, e.lk);
      end
      chk_eq("pass_fail_excl", bus.auth_pass & bus.auth_fail, 1'b0);
    end
  end

  task automatic do_reset();
    rst              = 1'b1;
    bus.auth_start   = 1'b0;
    bus.is_auth      = 1'b0;
    bus.auth_capture = 1'b0;
    bus.scan_data    = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_sig", bus.sig_out, SEED);
    chk_eq("rst_cnt", bus.shift_count, 16'h0);
    chk_eq("rst_valid", bus.result_valid, 1'b0);
    chk_eq("rst_pass", bus.auth_pass, 1'b0);
    chk_eq("rst_fail", bus.auth_fail, 1'b0);
    chk_eq("rst_fcnt", bus.fail_count, 8'h0);
    chk_eq("rst_locked", bus.locked, 1'b0);
    m_sig = SEED; m_cnt = '0; m_fcnt = '0; m_armed = 0; m_locked = 0;
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_step(input logic [7:0] d);
    m_sig = misr(m_sig, d);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic do_start();
    bus.auth_start = 1'b1;
    if (!m_locked) begin
      m_sig = SEED; m_cnt = '0; m_armed = 1;
    end
    @(negedge clk);
    bus.auth_start = 1'b0;
  endtask

  task automatic do_shift(input logic [7:0] d);
    bus.is_auth   = 1'b1;
    bus.scan_data = d;
    if (m_armed) model_step(d);
    @(negedge clk);
    bus.is_auth = 1'b0;
  endtask

  task automatic do_capture(input logic [15:0] lscan, input logic [31:0] esig,
                            input bit with_shift, input logic [7:0] d);
    exp_t e;
    bit   match;
    bus.auth_capture = 1'b1;
    bus.l_scan       = lscan;
    bus.expected_sig = esig;
    bus.is_auth      = with_shift;
    bus.scan_data    = d;
    if (m_armed) begin
      if (with_shift) model_step(d);
      match = (m_sig == esig) && (m_cnt == lscan);
      if (match) m_fcnt = '0;
      else if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
`ifdef PUF_LOCKOUT_EN
      if (!match && (m_fcnt >= MAX_FAILS)) m_locked = 1;
`endif
      e.pass = match; e.fail = !match; e.fcnt = m_fcnt; e.lk = m_locked;
      e.cyc  = cyc + 3;
      sb.push_back(e);
      m_armed = 0;
    end
    @(negedge clk);
    bus.auth_capture = 1'b0;
    bus.is_auth      = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    chk_eq("drain", sb.size(), 0);
    sb.delete();
    chk_eq("frozen_sig", bus.sig_out, m_sig);
    chk_eq("frozen_cnt", bus.shift_count, m_cnt);
  endtask

  initial begin
    bus.l_scan       = '0;
    bus.expected_sig = '0;
    @(negedge clk);
    do_reset();

    // all-zero window, four shifts
    do_start();
    for (int i = 0; i < 4; i++) do_shift(8'h00);
    do_capture(16'd4, 32'h0, 1'b0, 8'h00);
    chk_eq("zero_sig", bus.sig_out, 32'h0);
    chk_eq("zero_cnt", bus.shift_count, 16'd4);

    // known signature 0x2 passes, 0x1 fails
    do_start(); do_shift(8'h01); do_shift(8'h00);
    do_capture(16'd2, 32'h00000002, 1'b0, 8'h00);
    do_start(); do_shift(8'h01); do_shift(8'h00);
    do_capture(16'd2, 32'h00000001, 1'b0, 8'h00);
    chk_eq("known_fail_fcnt", bus.fail_count, 8'd1);

    // right signature, wrong count
    do_start();
    for (int i = 0; i < 4; i++) do_shift(8'(($urandom)));
    do_capture(16'd5, m_sig, 1'b0, 8'h00);
    chk_eq("cnt_mismatch_fail", bus.auth_fail, 1'b1);

    // restart mid-window discards earlier shifts
    do_start();
    for (int i = 0; i < 3; i++) do_shift(8'(($urandom)) | 8'h01);
    do_start();
    do_shift(8'h00); do_shift(8'h00);
    chk_eq("restart_cnt", bus.shift_count, 16'd2);
    chk_eq("restart_sig", bus.sig_out, SEED);
    do_capture(16'd2, SEED, 1'b0, 8'h00);

    // capture and is_auth while idle are ignored
    do_shift(8'hA5);
    do_capture(16'd0, 32'h0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);

    // random windows with gaps and a shift merged into capture
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      do_start();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        do_shift(8'(($urandom)));
      end
      if (r % 3 == 1)
        do_capture(m_cnt + 16'd1, m_sig ^ 32'h1, 1'b1, 8'h3C);
      else
        do_capture(m_cnt + 16'd1, misr(m_sig, 8'h3C), 1'b1, 8'h3C);
    end

`ifdef PUF_LOCKOUT_EN
    for (int r = 0; r < 3; r++) begin
      do_start(); do_shift(8'h11);
      do_capture(16'd7, 32'h0, 1'b0, 8'h00);
    end
    chk_eq("lock_set", bus.locked, 1'b1);
    do_start();
    do_shift(8'h55);
    chk_eq("lock_cnt_hold", bus.shift_count, m_cnt);
    do_capture(16'd0, 32'h0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    do_reset();
`else
    for (int r = 0; r < 300; r++) begin
      do_start();
      do_capture(16'd1, SEED, 1'b0, 8'h00);
    end
    chk_eq("sat_fcnt", bus.fail_count, 8'd255);
    chk_eq("sat_locked", bus.locked, 1'b0);
    do_start();
    do_capture(16'd0, SEED, 1'b0, 8'h00);
    chk_eq("pass_clears_fcnt", bus.fail_count, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
